// File: rtl/quad_rot.sv
// quad_rot: debounced quadrature encoder decoder driving a one-hot LED position and signed detent count.
// Bit 1 of the two-bit channel vectors is contact A, bit 0 is contact B.
module quad_rot #(
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enc_a,
   input  logic              enc_b,
   output logic [3:0]        led,
   output logic              step_cw,
   output logic              step_ccw,
   output logic              step_err,
   output logic signed [7:0] count
);
   localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);
   logic [1:0] s1, s, d, p;
   logic [19:0] c [2];
   logic signed [2:0] acc, sat;
   logic signed [3:0] sum;
   logic chg, both, cw_t, hit_cw, hit_ccw;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 2'b11;
         s <= 2'b11;
         d <= 2'b11;
         c[0] <= '0;
         c[1] <= '0;
      end else begin
         s1 <= {enc_a, enc_b};
         s <= s1;
         for (int i = 0; i < 2; i++)
            if (s[i] == d[i]) c[i] <= '0;
            else if (c[i] == LAST) begin
               d[i] <= s[i];
               c[i] <= '0;
            end else c[i] <= c[i] + 20'd1;
      end
   end
   assign chg = d != p;
   assign both = &(d ^ p);
   assign cw_t = (p == 2'b11 && d == 2'b10) || (p == 2'b10 && d == 2'b00) ||
                 (p == 2'b00 && d == 2'b01) || (p == 2'b01 && d == 2'b11);
   assign sum = {acc[2], acc} + (cw_t ? 4'sd1 : -4'sd1);
   assign sat = sum > 4'sd3 ? 3'sd3 : sum < -4'sd3 ? -3'sd3 : sum[2:0];
   // A step is only credited on return to the detent with a full four-transition run
   assign hit_cw = chg && !both && d == 2'b11 && sum == 4'sd4;
   assign hit_ccw = chg && !both && d == 2'b11 && sum == -4'sd4;
   always_ff @(posedge clk) begin
      if (rst) begin
         p <= 2'b11;
         acc <= '0;
         led <= 4'b0001;
         count <= '0;
         step_cw <= 1'b0;
         step_ccw <= 1'b0;
         step_err <= 1'b0;
      end else begin
         step_cw <= hit_cw;
         step_ccw <= hit_ccw;
         step_err <= chg && both;
         if (chg) begin
            p <= d;
            acc <= (both || d == 2'b11) ? 3'sd0 : sat;
         end
         if (hit_cw) begin
            led <= {led[2:0], led[3]};
            count <= count + 8'sd1;
         end else if (hit_ccw) begin
            led <= {led[0], led[3:1]};
            count <= count - 8'sd1;
         end
      end
   end
endmodule

// File: tb/tb_quad_rot.sv
// tb_quad_rot: scoreboard bench for quad_rot with a short debounce window.
module tb_quad_rot;
   localparam logic [2:0] CW = 3'b001, CCW = 3'b010, ERR = 3'b100;
   logic clk = 0, rst = 1, enc_a = 1, enc_b = 1;
   logic [3:0] led;
   logic step_cw, step_ccw, step_err;
   logic signed [7:0] count;
   typedef struct {
      logic [2:0] kind;
      logic [3:0] led;
      logic [7:0] cnt;
   } ev_t;
   ev_t sb[$];
   ev_t e;
   logic [2:0] k;
   logic [3:0] exp_led = 4'b0001;
   logic [7:0] exp_cnt = 8'd0;
   int tests = 0, fails = 0, cyc = 0, first_cw = -1;

   quad_rot #(.DEBOUNCE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .led(led),
      .step_cw(step_cw), .step_ccw(step_ccw), .step_err(step_err), .count(count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // every pulse must match the oldest outstanding expected event
   always @(negedge clk) begin
      k = {step_err, step_ccw, step_cw};
      if (!rst && k != 3'b000) begin
         if (step_cw && first_cw < 0) first_cw = cyc;
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse pulses=%b led=%b count=%0d, none expected", k, led, count);
         end else begin
            e = sb.pop_front();
            if (k !== e.kind || led !== e.led || count !== $signed(e.cnt)) begin
               fails++;
               $display("FAIL event pulses=%b led=%b count=%0d, expected pulses=%b led=%b count=%0d",
                        k, led, count, e.kind, e.led, $signed(e.cnt));
            end
         end
      end
   end

   task push(input logic [2:0] kd);
      if (kd == CW) begin
         exp_led = {exp_led[2:0], exp_led[3]};
         exp_cnt = exp_cnt + 8'd1;
      end else if (kd == CCW) begin
         exp_led = {exp_led[0], exp_led[3:1]};
         exp_cnt = exp_cnt - 8'd1;
      end
      sb.push_back('{kd, exp_led, exp_cnt});
   endtask

   task drive(input logic a, input logic b, input int hold);
      enc_a = a;
      enc_b = b;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task cw_detent(input int hold);
      push(CW);
      drive(1, 0, hold); drive(0, 0, hold); drive(0, 1, hold); drive(1, 1, hold);
   endtask

   task ccw_detent(input int hold);
      push(CCW);
      drive(0, 1, hold); drive(0, 0, hold); drive(1, 0, hold); drive(1, 1, hold);
   endtask

   task do_reset(input logic a, input logic b);
      enc_a = a;
      enc_b = b;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      sb.delete();
      exp_led = 4'b0001;
      exp_cnt = 8'd0;
   endtask

   task drain(input string name);
      repeat (20) @(posedge clk);
      #1;
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s_missing_events outstanding=%0d expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task test_reset;
      do_reset(1, 1);
      tests++;
      if (led !== 4'b0001 || count !== 8'sd0 || {step_err, step_ccw, step_cw} !== 3'b000) begin
         fails++;
         $display("FAIL reset led=%b count=%0d pulses=%b, expected 0001 0 000",
                  led, count, {step_err, step_ccw, step_cw});
      end
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         tests++;
         if (led !== 4'b0001 || count !== 8'sd0) begin
            fails++;
            $display("FAIL reset_hold cycle=%0d led=%b count=%0d, expected 0001 0", i, led, count);
         end
      end
   endtask

   task test_cw;
      int t;
      do_reset(1, 1);
      first_cw = -1;
      t = 0;
      for (int i = 0; i < 5; i++) begin
         push(CW);
         drive(1, 0, 10); drive(0, 0, 10); drive(0, 1, 10);
         if (i == 0) t = cyc;
         drive(1, 1, 10);
      end
      drain("cw");
      tests++;
      if (first_cw !== t + 7) begin
         fails++;
         $display("FAIL cw_latency pulse_cycle=%0d expected %0d", first_cw, t + 7);
      end
      tests++;
      if (led !== 4'b0010 || count !== 8'sd5) begin
         fails++;
         $display("FAIL cw_final led=%b count=%0d, expected 0010 5", led, count);
      end
   endtask

   task test_ccw_wrap;
      do_reset(1, 1);
      ccw_detent(6);
      drain("ccw");
      tests++;
      if (led !== 4'b1000 || count !== -8'sd1) begin
         fails++;
         $display("FAIL ccw led=%b count=%0d, expected 1000 -1", led, count);
      end
      do_reset(1, 1);
      for (int i = 0; i < 127; i++) cw_detent(6);
      drain("to127");
      tests++;
      if (count !== 8'sd127) begin
         fails++;
         $display("FAIL count_127 count=%0d expected 127", count);
      end
      cw_detent(6);
      drain("wrap");
      tests++;
      if (count !== -8'sd128 || led !== 4'b0001) begin
         fails++;
         $display("FAIL wrap count=%0d led=%b, expected -128 0001", count, led);
      end
   endtask

   task test_bounce;
      logic seq [16];
      logic last;
      int n;
      seq = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      do_reset(1, 1);
      last = 1;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         enc_a = seq[i];
         @(posedge clk);
         #1;
         if (dut.d[1] !== last) begin
            n++;
            last = dut.d[1];
         end
      end
      tests++;
      if (n != 1 || dut.d[1] !== 1'b0) begin
         fails++;
         $display("FAIL bounce_da changes=%0d d_a=%b, expected 1 0", n, dut.d[1]);
      end
      tests++;
      if (dut.acc !== 3'b111) begin
         fails++;
         $display("FAIL bounce_acc acc=%b expected 111", dut.acc);
      end
      push(CCW);
      drive(0, 0, 6); drive(1, 0, 6); drive(1, 1, 6);
      drain("bounce");
   endtask

   task test_partial_illegal;
      do_reset(1, 1);
      cw_detent(6);
      drive(1, 0, 8); drive(0, 0, 8); drive(1, 0, 8); drive(1, 1, 8);
      drain("partial");
      tests++;
      if (dut.acc !== 3'b000 || led !== 4'b0010 || count !== 8'sd1) begin
         fails++;
         $display("FAIL partial acc=%b led=%b count=%0d, expected 000 0010 1", dut.acc, led, count);
      end
      push(ERR);
      drive(0, 0, 10); drive(0, 1, 10); drive(1, 1, 10);
      drain("illegal");
      tests++;
      if (led !== 4'b0010 || count !== 8'sd1) begin
         fails++;
         $display("FAIL illegal led=%b count=%0d, expected 0010 1", led, count);
      end
   endtask

   task test_reset_mid;
      do_reset(1, 1);
      cw_detent(6);
      drain("pre_mid");
      drive(1, 0, 8); drive(0, 0, 8);
      do_reset(0, 0);
      tests++;
      if (led !== 4'b0001 || count !== 8'sd0 || {step_err, step_ccw, step_cw} !== 3'b000) begin
         fails++;
         $display("FAIL reset_mid led=%b count=%0d pulses=%b, expected 0001 0 000",
                  led, count, {step_err, step_ccw, step_cw});
      end
      push(ERR);
      drive(0, 0, 10); drive(0, 1, 10); drive(1, 1, 10);
      drain("reset_mid");
      tests++;
      if (led !== 4'b0001 || count !== 8'sd0) begin
         fails++;
         $display("FAIL reset_mid_after led=%b count=%0d, expected 0001 0", led, count);
      end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset;
      test_cw;
      test_ccw_wrap;
      test_bounce;
      test_partial_illegal;
      test_reset_mid;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
